// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcodes, the program-memory FSM states, and the
// canonical NOP instruction word.
package cpu_isa_pkg;

    typedef enum logic [4:0] {
        OP_NOP  = 5'b00000,
        OP_HALT = 5'b00001,
        OP_LDI  = 5'b00010,
        OP_ADD  = 5'b00011,
        OP_SUB  = 5'b00100,
        OP_JMP  = 5'b00101,
        OP_BEQ  = 5'b00110
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } pm_state_e;

    // Opcode lives in the top five bits; a NOP carries no operands.
    localparam logic [15:0] NOP_INSN = {OP_NOP, 11'b0};

endpackage

// File: rtl/prog_mem_loadable_if.sv
// Load stream and fetch port of the loadable program memory.
interface prog_mem_loadable_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;
    logic [ADDR_W:0]   prog_len;
    logic              fetch_en;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] douta;
    logic              dvalid;

    modport master (
        output ld_start, ld_valid, ld_data, ld_last, fetch_en, addra,
        input  ld_ready, ld_done, prog_len, douta, dvalid
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, fetch_en, addra,
        output ld_ready, ld_done, prog_len, douta, dvalid
    );
endinterface

// File: rtl/prog_ram_1r1w.sv
// Simple dual-port storage: synchronous write, synchronous read, no reset.
module prog_ram_1r1w #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clka,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clka) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/prog_mem_loadable.sv
// Program memory loaded over a valid/ready stream; fetches are guarded so
// only words of the current, completed program are ever returned.
module prog_mem_loadable
    import cpu_isa_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_INSN)
) (
    input  logic                 clka,
    input  logic                 rst,
    prog_mem_loadable_if.slave   bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);

    pm_state_e         state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   prog_len_q;
    logic              ld_ready_q;
    logic              ld_done_q;
    logic              dvalid_q;
    logic              hit_q;
    logic [DATA_W-1:0] ram_q;
    logic              accept;
    logic              done_now;
    logic              fetch_hit;

    // A restart takes priority over a word offered in the same cycle.
    assign accept    = bus.ld_valid && ld_ready_q && !bus.ld_start;
    assign done_now  = accept && (bus.ld_last || wr_ptr == LAST_ADDR);
    assign fetch_hit = (state == ST_RUN) && ({1'b0, bus.addra} < prog_len_q);

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            prog_len_q <= '0;
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            if (bus.ld_start) begin
                state      <= ST_LOAD;
                wr_ptr     <= '0;
                prog_len_q <= '0;
                ld_ready_q <= 1'b1;
            end else if (done_now) begin
                state      <= ST_RUN;
                prog_len_q <= {1'b0, wr_ptr} + LEN_ONE;
                ld_ready_q <= 1'b0;
                ld_done_q  <= 1'b1;
            end else if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
        end
    end

    // The hit flag masks the unreset RAM output, so reset alone yields NOP.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            dvalid_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            dvalid_q <= bus.fetch_en;
            if (bus.fetch_en) hit_q <= fetch_hit;
        end
    end

    prog_ram_1r1w #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clka  (clka),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (bus.ld_data),
        .re    (bus.fetch_en),
        .raddr (bus.addra),
        .rdata (ram_q)
    );

    assign bus.ld_ready = ld_ready_q;
    assign bus.ld_done  = ld_done_q;
    assign bus.prog_len = prog_len_q;
    assign bus.dvalid   = dvalid_q;
    assign bus.douta    = hit_q ? ram_q : NOP_WORD;
endmodule

// File: doc/prog_mem_loadable.md
PROG_MEM_LOADABLE -- requirements
Module: prog_mem_loadable

Interface
REQ-001 Parameter DATA_W, default 16, instruction word width.
REQ-002 Parameter ADDR_W, default 8, address width; depth = 2**ADDR_W.
REQ-003 Parameter NOP_WORD, default 16'h0000, word returned for unloaded or blocked fetches.
REQ-004 Port clka  input  1  single clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port ld_start  input  1  pulse: begin a program load at address 0.
REQ-007 Port ld_valid  input  1  ld_data carries a word.
REQ-008 Port ld_data  input  DATA_W  program word to write.
REQ-009 Port ld_last  input  1  qualifies the final word of the load.
REQ-010 Port ld_ready  output  1  block accepts ld_data this cycle.
REQ-011 Port ld_done  output  1  one-cycle pulse when a load completes.
REQ-012 Port prog_len  output  ADDR_W+1  number of valid loaded words.
REQ-013 Port fetch_en  input  1  fetch request.
REQ-014 Port addra  input  ADDR_W  fetch address.
REQ-015 Port douta  output  DATA_W  fetched instruction, registered.
REQ-016 Port dvalid  output  1  douta holds a result for the fetch issued one cycle earlier.

Function
REQ-017 FSM states: IDLE (no program), LOAD, RUN; transitions are IDLE->LOAD or RUN->LOAD on ld_start, LOAD->RUN on completion, and no other transitions.
REQ-018 ld_ready shall be 1 only in LOAD; a word is accepted when ld_valid && ld_ready and is written to mem[wr_ptr], after which wr_ptr increments.
REQ-019 Load completes when an accepted word has ld_last=1, or when the accepted word is at address 2**ADDR_W-1, with wr_ptr never wrapping.
REQ-020 On completion: prog_len = wr_ptr+1, ld_done pulses in the next cycle, and the state becomes RUN.
REQ-021 ld_start in LOAD restarts the load: wr_ptr=0, prog_len=0, and already written words are treated as unloaded.
REQ-022 On entering LOAD, prog_len shall clear to 0 in the same cycle.
REQ-023 Fetch latency is exactly 1 cycle: a fetch_en at cycle N yields douta/dvalid=1 at cycle N+1; when fetch_en=0, dvalid=0 at N+1 and douta holds its previous value.
REQ-024 The fetch returns mem[addra] only when the state is RUN and addra < prog_len; otherwise it returns NOP_WORD with dvalid=1.
REQ-025 A fetch to the address being written in the same cycle returns NOP_WORD, because the FSM is in LOAD.
REQ-026 Arithmetic: prog_len is ADDR_W+1 bits wide so that a full load reports 2**ADDR_W; address comparison is unsigned.

Reset
REQ-027 On rst: state=IDLE, wr_ptr=0, prog_len=0, ld_ready=0, ld_done=0, dvalid=0, douta=NOP_WORD.
REQ-028 Memory array contents are not reset; prog_len=0 guarantees that every fetch returns NOP_WORD.
REQ-029 Asserting rst mid-load abandons the load; after release the block stays in IDLE until ld_start.

Structure
REQ-030 Opcode constants (NOP=00000, HALT=00001, ...) and the FSM state encoding shall reside in shared package cpu_isa_pkg; NOP_WORD defaults from it.
REQ-031 The storage array shall be a separate sub-module prog_ram_1r1w (sync write, sync read, ADDR_W/DATA_W parameters); the FSM and fetch guard stay in the top module.

Verification
REQ-032 Reset, then fetch addra=0..3 -> douta=16'h0000 and dvalid=1 one cycle after each fetch_en.
REQ-033 ld_start, then 3 words 16'h1234, 16'h0800, 16'hABCD with ld_last on the third -> ld_done pulse, prog_len=3; fetch 0,1,2,3 -> 16'h1234, 16'h0800, 16'hABCD, 16'h0000.
REQ-034 ADDR_W=4: load 16 words without ld_last -> auto-complete after word 15, prog_len=16, ld_ready=0 afterwards, fetch 15 returns the last word.
REQ-035 ld_valid toggled randomly during a 5-word load -> only accepted words are written, in order, and prog_len=5.
REQ-036 Assert rst after 2 of 4 words -> state IDLE, prog_len=0, fetch 0 returns 16'h0000; a new full load then succeeds.
REQ-037 ld_start in RUN with prog_len=3, then fetch 0 during LOAD -> 16'h0000; after a 1-word reload, prog_len=1 and fetch 1 returns 16'h0000.
